// File: rtl/wb_stage_reg_pkg.sv
// ============================================================================
// wb_stage_reg_pkg
// Shared Y86 constants: word sizes, instruction codes, status codes, RNONE.
// Revision: 1.0
// ============================================================================
`default_nettype none

package wb_stage_reg_pkg;

    localparam int NIBBLE = 4;
    localparam int WORD   = 32;

    localparam int ICODE_HALT = 0;
    localparam int ICODE_NOP  = 1;

    localparam int STAT_AOK = 1;
    localparam int STAT_HLT = 2;
    localparam int STAT_ADR = 3;
    localparam int STAT_INS = 4;

    // RNONE is the all-ones register ID at whatever register width is in use.
    function automatic int rnone(input int reg_w);
        return (1 << reg_w) - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_stage_reg_pipe_field_reg.sv
// ============================================================================
// pipe_field_reg
// One pipeline-register field with synchronous reset, hold and bubble load.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_field_reg #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_hold,
    input  logic             i_bubble,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Hold outranks bubble so a stalled stage keeps its instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RESET_VAL;
        end else if (i_hold) begin
            r_q <= r_q;
        end else if (i_bubble) begin
            r_q <= BUBBLE_VAL;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/wb_stage_reg.sv
// ============================================================================
// wb_stage_reg
// Y86 Write-back pipeline register with stall/bubble, sticky halt,
// register-file write enables and a retired-instruction counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_stage_reg
    import wb_stage_reg_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int ICODE_W = 4,
    parameter int REG_W   = 4,
    parameter int STAT_W  = 3,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               W_stall_i,
    input  logic               W_bubble_i,
    input  logic [ICODE_W-1:0] M_icode_i,
    input  logic [STAT_W-1:0]  M_stat_i,
    input  logic [WORD_W-1:0]  M_valE_i,
    input  logic [WORD_W-1:0]  m_valM_i,
    input  logic [REG_W-1:0]   M_dstE_i,
    input  logic [REG_W-1:0]   M_dstM_i,
    output logic [ICODE_W-1:0] W_icode_o,
    output logic [STAT_W-1:0]  W_stat_o,
    output logic [WORD_W-1:0]  W_valE_o,
    output logic [WORD_W-1:0]  W_valM_o,
    output logic [REG_W-1:0]   W_dstE_o,
    output logic [REG_W-1:0]   W_dstM_o,
    output logic               W_wenE_o,
    output logic               W_wenM_o,
    output logic               W_halted_o,
    output logic [CNT_W-1:0]   W_retired_o
);

    localparam logic [ICODE_W-1:0] c_ICODE_NOP = ICODE_W'(ICODE_NOP);
    localparam logic [STAT_W-1:0]  c_STAT_AOK  = STAT_W'(STAT_AOK);
    localparam logic [REG_W-1:0]   c_RNONE     = {REG_W{1'b1}};

    logic             r_halted;
    logic [CNT_W-1:0] r_retired;
    logic             w_hold;
    logic             w_load;

    // Once halted, the whole stage freezes regardless of stall/bubble.
    assign w_hold = r_halted | W_stall_i;
    assign w_load = ~w_hold & ~W_bubble_i;

    pipe_field_reg #(.WIDTH(ICODE_W), .RESET_VAL(c_ICODE_NOP), .BUBBLE_VAL(c_ICODE_NOP)) u_icode (
        .clk(clk), .rst(rst), .i_hold(w_hold), .i_bubble(W_bubble_i), .i_d(M_icode_i), .o_q(W_icode_o));
    pipe_field_reg #(.WIDTH(STAT_W), .RESET_VAL(c_STAT_AOK), .BUBBLE_VAL(c_STAT_AOK)) u_stat (
        .clk(clk), .rst(rst), .i_hold(w_hold), .i_bubble(W_bubble_i), .i_d(M_stat_i), .o_q(W_stat_o));
    pipe_field_reg #(.WIDTH(WORD_W), .RESET_VAL('0), .BUBBLE_VAL('0)) u_valE (
        .clk(clk), .rst(rst), .i_hold(w_hold), .i_bubble(W_bubble_i), .i_d(M_valE_i), .o_q(W_valE_o));
    pipe_field_reg #(.WIDTH(WORD_W), .RESET_VAL('0), .BUBBLE_VAL('0)) u_valM (
        .clk(clk), .rst(rst), .i_hold(w_hold), .i_bubble(W_bubble_i), .i_d(m_valM_i), .o_q(W_valM_o));
    pipe_field_reg #(.WIDTH(REG_W), .RESET_VAL(c_RNONE), .BUBBLE_VAL(c_RNONE)) u_dstE (
        .clk(clk), .rst(rst), .i_hold(w_hold), .i_bubble(W_bubble_i), .i_d(M_dstE_i), .o_q(W_dstE_o));
    pipe_field_reg #(.WIDTH(REG_W), .RESET_VAL(c_RNONE), .BUBBLE_VAL(c_RNONE)) u_dstM (
        .clk(clk), .rst(rst), .i_hold(w_hold), .i_bubble(W_bubble_i), .i_d(M_dstM_i), .o_q(W_dstM_o));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_halted  <= 1'b0;
            r_retired <= '0;
        end else if (w_load) begin
            if (M_stat_i != c_STAT_AOK) begin
                r_halted <= 1'b1;
            end else if (M_icode_i != c_ICODE_NOP) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign W_halted_o  = r_halted;
    assign W_retired_o = r_retired;
    assign W_wenE_o    = (W_dstE_o != c_RNONE) && (W_stat_o == c_STAT_AOK) && !r_halted;
    assign W_wenM_o    = (W_dstM_o != c_RNONE) && (W_stat_o == c_STAT_AOK) && !r_halted;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage_reg.sv
// ============================================================================
// tb_wb_stage_reg
// Self-checking bench: directed vector table, hand sequences, random vs model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_wb_stage_reg;

    logic        clk = 1'b0;
    logic        rst, W_stall_i, W_bubble_i;
    logic [3:0]  M_icode_i;
    logic [2:0]  M_stat_i;
    logic [31:0] M_valE_i, m_valM_i;
    logic [3:0]  M_dstE_i, M_dstM_i;
    logic [3:0]  W_icode_o;
    logic [2:0]  W_stat_o;
    logic [31:0] W_valE_o, W_valM_o;
    logic [3:0]  W_dstE_o, W_dstM_o;
    logic        W_wenE_o, W_wenM_o, W_halted_o;
    logic [3:0]  W_retired_o;

    wb_stage_reg #(.WORD_W(32), .ICODE_W(4), .REG_W(4), .STAT_W(3), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .W_stall_i(W_stall_i), .W_bubble_i(W_bubble_i),
        .M_icode_i(M_icode_i), .M_stat_i(M_stat_i), .M_valE_i(M_valE_i), .m_valM_i(m_valM_i),
        .M_dstE_i(M_dstE_i), .M_dstM_i(M_dstM_i),
        .W_icode_o(W_icode_o), .W_stat_o(W_stat_o), .W_valE_o(W_valE_o), .W_valM_o(W_valM_o),
        .W_dstE_o(W_dstE_o), .W_dstM_o(W_dstM_o), .W_wenE_o(W_wenE_o), .W_wenM_o(W_wenM_o),
        .W_halted_o(W_halted_o), .W_retired_o(W_retired_o));

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state (plain integers, retire count kept modulo 16)
    int mi, ms, mve, mvm, mde, mdm, mh, mr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input logic r, input logic st, input logic bb, input logic [3:0] ic,
                         input logic [2:0] sa, input logic [31:0] ve, input logic [31:0] vm,
                         input logic [3:0] de, input logic [3:0] dm);
        rst = r; W_stall_i = st; W_bubble_i = bb; M_icode_i = ic; M_stat_i = sa;
        M_valE_i = ve; m_valM_i = vm; M_dstE_i = de; M_dstM_i = dm;
    endtask

    function automatic void model_update();
        if (rst) begin
            mi = 1; ms = 1; mve = 0; mvm = 0; mde = 15; mdm = 15; mh = 0; mr = 0;
        end else if (mh != 0 || W_stall_i) begin
            // frozen
        end else if (W_bubble_i) begin
            mi = 1; ms = 1; mve = 0; mvm = 0; mde = 15; mdm = 15;
        end else begin
            mi = int'(M_icode_i); ms = int'(M_stat_i); mve = int'(M_valE_i);
            mvm = int'(m_valM_i); mde = int'(M_dstE_i); mdm = int'(M_dstM_i);
            if (ms != 1) mh = 1;
            else if (mi != 1) mr = (mr + 1) % 16;
        end
    endfunction

    // Apply current inputs for one clock and compare every output with the model.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        chk("m_icode",  64'(W_icode_o),   64'(mi));
        chk("m_stat",   64'(W_stat_o),    64'(ms));
        chk("m_valE",   64'(W_valE_o),    64'(unsigned'(mve)));
        chk("m_valM",   64'(W_valM_o),    64'(unsigned'(mvm)));
        chk("m_dstE",   64'(W_dstE_o),    64'(mde));
        chk("m_dstM",   64'(W_dstM_o),    64'(mdm));
        chk("m_wenE",   64'(W_wenE_o),    64'(mde != 15 && ms == 1 && mh == 0));
        chk("m_wenM",   64'(W_wenM_o),    64'(mdm != 15 && ms == 1 && mh == 0));
        chk("m_halted", 64'(W_halted_o),  64'(mh));
        chk("m_retired",64'(W_retired_o), 64'(mr));
    endtask

    typedef struct {
        logic        r, st, bb;
        logic [3:0]  ic;
        logic [2:0]  sa;
        logic [31:0] ve, vm;
        logic [3:0]  de, dm;
        logic [3:0]  e_ic;
        logic [2:0]  e_sa;
        logic [31:0] e_ve, e_vm;
        logic [3:0]  e_de, e_dm;
        logic        e_wenE, e_wenM, e_h;
        logic [3:0]  e_ret;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [3:0] saved_ret;
        tbl[0]  = '{1'b1,1'b0,1'b0, 4'h0,3'd0,32'h0,32'h0,4'h0,4'h0, 4'h1,3'd1,32'h0,32'h0,4'hF,4'hF,1'b0,1'b0,1'b0,4'd0};
        tbl[1]  = tbl[0];
        tbl[2]  = '{1'b0,1'b0,1'b0, 4'h6,3'd1,32'h15,32'h0,4'h3,4'hF, 4'h6,3'd1,32'h15,32'h0,4'h3,4'hF,1'b1,1'b0,1'b0,4'd1};
        tbl[3]  = '{1'b0,1'b0,1'b0, 4'h5,3'd1,32'h20,32'hAB,4'hF,4'h2, 4'h5,3'd1,32'h20,32'hAB,4'hF,4'h2,1'b0,1'b1,1'b0,4'd2};
        tbl[4]  = '{1'b0,1'b0,1'b0, 4'h2,3'd1,32'h7,32'h0,4'h2,4'hF, 4'h2,3'd1,32'h7,32'h0,4'h2,4'hF,1'b1,1'b0,1'b0,4'd3};
        tbl[5]  = '{1'b0,1'b1,1'b1, 4'h6,3'd1,32'h99,32'h0,4'h4,4'h4, 4'h2,3'd1,32'h7,32'h0,4'h2,4'hF,1'b1,1'b0,1'b0,4'd3};
        tbl[6]  = tbl[5];
        tbl[7]  = tbl[5];
        tbl[8]  = '{1'b0,1'b0,1'b1, 4'h6,3'd1,32'h99,32'h0,4'h4,4'h4, 4'h1,3'd1,32'h0,32'h0,4'hF,4'hF,1'b0,1'b0,1'b0,4'd3};
        tbl[9]  = '{1'b0,1'b0,1'b0, 4'h1,3'd1,32'h0,32'h0,4'hF,4'hF, 4'h1,3'd1,32'h0,32'h0,4'hF,4'hF,1'b0,1'b0,1'b0,4'd3};
        tbl[10] = '{1'b0,1'b1,1'b0, 4'h6,3'd1,32'h5,32'h0,4'h3,4'h3, 4'h1,3'd1,32'h0,32'h0,4'hF,4'hF,1'b0,1'b0,1'b0,4'd3};
        tbl[11] = '{1'b0,1'b0,1'b0, 4'h5,3'd3,32'h40,32'h0,4'hF,4'h4, 4'h5,3'd3,32'h40,32'h0,4'hF,4'h4,1'b0,1'b0,1'b1,4'd3};
        tbl[12] = '{1'b0,1'b0,1'b0, 4'h6,3'd1,32'h1,32'h0,4'h3,4'h3, 4'h5,3'd3,32'h40,32'h0,4'hF,4'h4,1'b0,1'b0,1'b1,4'd3};
        tbl[13] = '{1'b1,1'b0,1'b0, 4'h6,3'd1,32'h1,32'h0,4'h3,4'h3, 4'h1,3'd1,32'h0,32'h0,4'hF,4'hF,1'b0,1'b0,1'b0,4'd0};

        drive(1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 32'h0, 32'h0, 4'h0, 4'h0);
        #1;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].r, tbl[i].st, tbl[i].bb, tbl[i].ic, tbl[i].sa,
                  tbl[i].ve, tbl[i].vm, tbl[i].de, tbl[i].dm);
            step();
            chk($sformatf("v%0d_icode", i),   64'(W_icode_o),   64'(tbl[i].e_ic));
            chk($sformatf("v%0d_stat", i),    64'(W_stat_o),    64'(tbl[i].e_sa));
            chk($sformatf("v%0d_valE", i),    64'(W_valE_o),    64'(tbl[i].e_ve));
            chk($sformatf("v%0d_valM", i),    64'(W_valM_o),    64'(tbl[i].e_vm));
            chk($sformatf("v%0d_dstE", i),    64'(W_dstE_o),    64'(tbl[i].e_de));
            chk($sformatf("v%0d_dstM", i),    64'(W_dstM_o),    64'(tbl[i].e_dm));
            chk($sformatf("v%0d_wenE", i),    64'(W_wenE_o),    64'(tbl[i].e_wenE));
            chk($sformatf("v%0d_wenM", i),    64'(W_wenM_o),    64'(tbl[i].e_wenM));
            chk($sformatf("v%0d_halted", i),  64'(W_halted_o),  64'(tbl[i].e_h));
            chk($sformatf("v%0d_retired", i), 64'(W_retired_o), 64'(tbl[i].e_ret));
        end

        // Halt freeze: HLT load, five AOK loads ignored, reset releases.
        drive(1'b0, 1'b0, 1'b0, 4'h6, 3'd1, 32'h11, 32'h0, 4'h3, 4'hF);
        step();
        saved_ret = W_retired_o;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 3'd2, 32'h0, 32'h0, 4'hF, 4'hF);
        step();
        chk("hlt_halted", 64'(W_halted_o), 64'd1);
        chk("hlt_stat",   64'(W_stat_o),   64'd2);
        chk("hlt_wenE",   64'(W_wenE_o),   64'd0);
        chk("hlt_wenM",   64'(W_wenM_o),   64'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, i[0], 1'b0, 4'h6, 3'd1, 32'h100 + 32'(i), 32'h5, 4'h3, 4'h4);
            step();
            chk("hlt_icode_held", 64'(W_icode_o),   64'd0);
            chk("hlt_ret_held",   64'(W_retired_o), 64'(saved_ret));
        end
        drive(1'b1, 1'b0, 1'b0, 4'h6, 3'd1, 32'h0, 32'h0, 4'h3, 4'h4);
        step();
        chk("hlt_rst_release", 64'(W_halted_o), 64'd0);

        // Counter wrap at CNT_W=4 with NOP loads interleaved.
        for (int i = 0; i < 17; i++) begin
            drive(1'b0, 1'b0, 1'b0, 4'h6, 3'd1, 32'(i), 32'h0, 4'h3, 4'hF);
            step();
            if (i == 15) chk("wrap_at_16", 64'(W_retired_o), 64'd0);
            drive(1'b0, 1'b0, 1'b0, 4'h1, 3'd1, 32'h0, 32'h0, 4'hF, 4'hF);
            step();
        end
        chk("wrap_17", 64'(W_retired_o), 64'd1);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(63) == 0),
                  ($urandom_range(4) == 0),
                  ($urandom_range(4) == 0),
                  4'($urandom_range(11)),
                  ($urandom_range(29) == 0) ? 3'($urandom_range(4, 2)) : 3'd1,
                  $urandom, $urandom,
                  4'($urandom), 4'($urandom));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
